prv32_muldiv_seq: RTL and testbench
===================================

Name: prv32_muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M instructions (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Adds no adder of its own; it borrows the core's prv32_ALU through a mux selected by alu_own and runs iterative shift-add multiply and restoring divide.
- Sits beside the single-cycle core. The core stalls while busy=1 and captures result when done=1.

Parameters:
- XLEN, 32, operand/result width. The ALU contract is 32-bit; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  32  dividend / multiplicand
- rs2  in  32  divisor / multiplier
- busy  out  1  high from the cycle after start acceptance until done
- done  out  1  one-cycle pulse; result valid
- result  out  32  final value; held until the next accepted start
- alu_own  out  1  core ALU mux select; 1 means this block drives the ALU
- alu_a  out  32  ALU a
- alu_b  out  32  ALU b
- alu_shamt  out  5  driven 0
- alu_alufn  out  4  0000 ADD or 0001 SUB only
- alu_r  in  32  ALU result
- alu_cf  in  1  adder carry-out; for SUB, 1 iff a>=b unsigned
- alu_zf  in  1  unused; tie-off permitted

Behaviour:
Reset:
- rst=1 at any edge forces IDLE.
- busy, done, alu_own, result, alu_a, alu_b and alu_alufn all become 0. Internal hi, lo and sign flags are cleared.
- Reset mid-operation aborts without a done pulse.

Start:
- start=1 in IDLE latches op, rs1 and rs2.
- start in any other state is ignored.

States and transitions:
- IDLE.
  - Divide with rs2==0 goes to DONE with quotient 0xFFFFFFFF, remainder rs1.
  - DIV/REM with rs1==0x80000000 and rs2==0xFFFFFFFF goes to DONE with quotient 0x80000000, remainder 0.
  - All other requests go to NEG_A.
- NEG_A:
  - If rs1 is treated signed (MULH, MULHSU, DIV, REM) and rs1[31]=1: a_mag = ALU SUB(0, rs1).
  - Otherwise a_mag = ALU ADD(rs1, 0).
  - Go to NEG_B.
- NEG_B:
  - Same rule for rs2; rs2 is treated signed only for MULH, DIV and REM.
  - Initialise: mul hi=0, lo=b_mag, mcand=a_mag; div hi=0, lo=a_mag, divisor=b_mag.
  - Counter=0. Go to ITER.
- ITER (exactly 32 cycles; counter 0..31, wraps to FIX_LO after 31).
  - Mul:
    - ALU ADD(hi, mcand).
    - If lo[0]: {hi,lo} <= {cf, alu_r, lo[31:1]}.
    - Else: {hi,lo} <= {1'b0, hi, lo[31:1]}.
  - Div:
    - alu_a = {hi[30:0], lo[31]}; ALU SUB(alu_a, divisor).
    - take = hi[31] | cf.
    - hi <= take ? alu_r : alu_a.
    - lo <= {lo[30:0], take}.
- FIX_LO:
  - Mul with neg_p = sa^sb (MULHSU: sa): lo <= ALU SUB(0, lo), and latch borrow_zero = cf (1 iff lo was 0).
  - Div with neg_q = sa^sb: lo <= SUB(0, lo).
  - Otherwise ADD(lo, 0).
- FIX_HI:
  - Mul with neg_p: hi <= ALU ADD(~hi, {31'b0, borrow_zero}).
  - Div with neg_r = sa: hi <= SUB(0, hi).
  - Otherwise ADD(hi, 0).
- DONE:
  - done=1 and result registered: MUL lo; MULH/MULHSU/MULHU hi; DIV/DIVU lo; REM/REMU hi.
  - Go to IDLE. A start in the same cycle is ignored; start is accepted from IDLE only.

Timing:
- Normal latency: done asserts exactly 37 cycles after the accepting edge.
- Special cases: done asserts 1 cycle after the accepting edge.
- alu_own=1 exactly in NEG_A..FIX_HI (36 cycles); 0 in IDLE and DONE. ALU outputs are 0 when alu_own=0.
- busy=1 in NEG_A..FIX_HI and DONE.

Arithmetic:
- All operations are modulo 2^32.
- MUL low word is sign-agnostic and computed unsigned.

Decomposition:
- prv32_pkg holds:
  - ALU opcode constants (ALU_ADD=4'b0000, ALU_SUB=4'b0001);
  - funct3 constants for the eight ops;
  - the state enum IDLE/NEG_A/NEG_B/ITER/FIX_LO/FIX_HI/DONE;
  - ITER_COUNT=32.
- Single module; no sub-module. Sign-select decode stays a local function.

Test Plan:
- MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, done at cycle 37, alu_own high for 36 cycles.
- MULH 0xFFFFFFFE x 3 -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0xFFFFFFFF / 0x80000001 -> 1 (exercises hi[31] take).
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, done 1 cycle after start, alu_own never high; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
- rst=1 at cycle 10 of a MUL -> next edge busy=0, done=0, alu_own=0, result=0, no done pulse; a following MUL 3x4 -> 12 at cycle 37.
- start pulsed repeatedly while busy with different operands -> ignored; result matches the first request only, then a new start in IDLE is accepted.

Source files
------------

// File: rtl/prv32_pkg.sv
// Shared constants for the RV32M sequencer: ALU opcodes, funct3 encodings and FSM states.
package prv32_pkg;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;

  localparam logic [2:0] F3Mul    = 3'b000;
  localparam logic [2:0] F3Mulh   = 3'b001;
  localparam logic [2:0] F3Mulhsu = 3'b010;
  localparam logic [2:0] F3Mulhu  = 3'b011;
  localparam logic [2:0] F3Div    = 3'b100;
  localparam logic [2:0] F3Divu   = 3'b101;
  localparam logic [2:0] F3Rem    = 3'b110;
  localparam logic [2:0] F3Remu   = 3'b111;

  localparam int unsigned IterCount = 32;

  typedef enum logic [2:0] {
    StIdle,
    StNegA,
    StNegB,
    StIter,
    StFixLo,
    StFixHi,
    StDone
  } md_state_e;

endpackage

// File: rtl/prv32_muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer; all arithmetic goes through the core's ALU.
// Shift-add multiply and restoring divide on operand magnitudes, sign fixed up at the end.
module prv32_muldiv_seq
  import prv32_pkg::*;
#(
  parameter int unsigned Xlen = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [Xlen-1:0] rs1,
  input  logic [Xlen-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [Xlen-1:0] result,
  output logic            alu_own,
  output logic [Xlen-1:0] alu_a,
  output logic [Xlen-1:0] alu_b,
  output logic [4:0]      alu_shamt,
  output logic [3:0]      alu_alufn,
  input  logic [Xlen-1:0] alu_r,
  input  logic            alu_cf,
  input  logic            alu_zf
);

  localparam logic [Xlen-1:0] MinNeg = {1'b1, {(Xlen-1){1'b0}}};
  localparam logic [4:0]      CntLast = 5'(IterCount - 1);

  // {rs1 signed, rs2 signed}
  function automatic logic [1:0] sign_sel(input logic [2:0] f3);
    case (f3)
      F3Mulh, F3Div, F3Rem: sign_sel = 2'b11;
      F3Mulhsu:             sign_sel = 2'b10;
      default:              sign_sel = 2'b00;
    endcase
  endfunction

  md_state_e       state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [Xlen-1:0] hi_q, hi_d, lo_q, lo_d, mag_q, mag_d, result_q, result_d;
  logic            sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [Xlen-1:0] div_sh;
  logic            is_div, neg_p, take;
  logic            unused_zf;

  assign unused_zf = alu_zf;
  assign is_div    = op_q[2];
  assign neg_p     = sa_q ^ sb_q;
  assign div_sh    = {hi_q[Xlen-2:0], lo_q[Xlen-1]};

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign result    = result_q;
  assign alu_shamt = 5'd0;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mag_d     = mag_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    bz_d      = bz_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    take      = 1'b0;
    alu_own   = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_alufn = AluAdd;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d         = op;
          hi_d         = rs1;
          lo_d         = rs2;
          {sa_d, sb_d} = sign_sel(op) & {rs1[Xlen-1], rs2[Xlen-1]};
          if (op[2] && rs2 == '0) begin
            state_d  = StDone;
            result_d = op[1] ? rs1 : '1;
          end else if (op[2] && !op[0] && rs1 == MinNeg && rs2 == '1) begin
            state_d  = StDone;
            result_d = op[1] ? '0 : MinNeg;
          end else begin
            state_d = StNegA;
          end
        end
      end
      StNegA: begin
        alu_own = 1'b1;
        if (sa_q) begin
          alu_b     = hi_q;
          alu_alufn = AluSub;
        end else begin
          alu_a = hi_q;
        end
        mag_d   = alu_r;
        state_d = StNegB;
      end
      StNegB: begin
        alu_own = 1'b1;
        if (sb_q) begin
          alu_b     = lo_q;
          alu_alufn = AluSub;
        end else begin
          alu_a = lo_q;
        end
        hi_d = '0;
        // Divide keeps the dividend in lo and the divisor in mag; multiply the reverse.
        if (is_div) begin
          lo_d  = mag_q;
          mag_d = alu_r;
        end else begin
          lo_d = alu_r;
        end
        cnt_d   = '0;
        state_d = StIter;
      end
      StIter: begin
        alu_own = 1'b1;
        alu_b   = mag_q;
        if (is_div) begin
          alu_a     = div_sh;
          alu_alufn = AluSub;
          take      = hi_q[Xlen-1] | alu_cf;
          hi_d      = take ? alu_r : div_sh;
          lo_d      = {lo_q[Xlen-2:0], take};
        end else begin
          alu_a = hi_q;
          if (lo_q[0]) begin
            {hi_d, lo_d} = {alu_cf, alu_r, lo_q[Xlen-1:1]};
          end else begin
            {hi_d, lo_d} = {1'b0, hi_q, lo_q[Xlen-1:1]};
          end
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == CntLast) begin
          state_d = StFixLo;
        end
      end
      StFixLo: begin
        alu_own = 1'b1;
        if (neg_p) begin
          alu_b     = lo_q;
          alu_alufn = AluSub;
          if (!is_div) begin
            bz_d = alu_cf;
          end
        end else begin
          alu_a = lo_q;
        end
        lo_d    = alu_r;
        state_d = StFixHi;
      end
      StFixHi: begin
        alu_own = 1'b1;
        // 64-bit negate of the product: hi gets ~hi plus the borrow out of the low word.
        if (!is_div && neg_p) begin
          alu_a = ~hi_q;
          alu_b = {{(Xlen-1){1'b0}}, bz_q};
        end else if (is_div && sa_q) begin
          alu_b     = hi_q;
          alu_alufn = AluSub;
        end else begin
          alu_a = hi_q;
        end
        hi_d     = alu_r;
        result_d = (op_q == F3Mul || op_q[2:1] == 2'b10) ? lo_q : alu_r;
        state_d  = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mag_q    <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bz_q     <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mag_q    <= mag_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      bz_q     <= bz_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_prv32_muldiv_seq.sv
// Bench for prv32_muldiv_seq: behavioural ALU, 64-bit arithmetic reference model,
// directed and randomized operations, mid-operation reset and start-while-busy scenarios.
module tb_prv32_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  op;
  logic [31:0] rs1, rs2, result, alu_a, alu_b, alu_r;
  logic        busy, done, alu_own, alu_cf, alu_zf;
  logic [4:0]  alu_shamt;
  logic [3:0]  alu_alufn;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prv32_muldiv_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .alu_own   (alu_own),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_shamt (alu_shamt),
    .alu_alufn (alu_alufn),
    .alu_r     (alu_r),
    .alu_cf    (alu_cf),
    .alu_zf    (alu_zf)
  );

  // Core ALU stand-in: ADD reports carry-out, SUB reports a>=b unsigned.
  always_comb begin
    if (alu_alufn == 4'b0001) begin
      alu_r  = alu_a - alu_b;
      alu_cf = (alu_a >= alu_b);
    end else begin
      {alu_cf, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
    end
  end
  assign alu_zf = (alu_r == 32'd0);

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    case (o)
      3'b000: begin p = {32'b0, a} * {32'b0, b};             return p[31:0];  end
      3'b001: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'b010: begin p = {{32{a[31]}}, a} * {32'b0, b};       return p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b};             return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issues one request from IDLE and observes it until the done pulse (or a 60-cycle bound).
  // viol counts protocol breaches: ALU outputs live while not owned, bad alufn/shamt,
  // busy dropping early, done lasting more than one cycle, result not held.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int own,
                       output int viol);
    res  = '0;
    lat  = -1;
    own  = 0;
    viol = 0;
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (alu_own) own++;
      else if (alu_a != 0 || alu_b != 0 || alu_alufn != 0) viol++;
      if (alu_shamt != 0 || alu_alufn > 4'd1) viol++;
      if (busy !== 1'b1) viol++;
      if (done === 1'b1) begin
        lat = n;
        res = result;
        break;
      end
    end
    @(negedge clk);
    if (done !== 1'b0 || busy !== 1'b0 || alu_own !== 1'b0 || result !== res) viol++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 7;
    if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    if (alu_own !== 1'b0)   begin errors++; $display("FAIL reset_own: got %b expected 0", alu_own); end
    if (result !== 32'd0)   begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    if (alu_a !== 32'd0)    begin errors++; $display("FAIL reset_alu_a: got %h expected 0", alu_a); end
    if (alu_b !== 32'd0)    begin errors++; $display("FAIL reset_alu_b: got %h expected 0", alu_b); end
    if (alu_alufn !== 4'd0) begin errors++; $display("FAIL reset_alufn: got %h expected 0", alu_alufn); end
    rst = 1'b0;
  endtask

  logic [2:0]  v_op [13] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101, 3'b111,
                             3'b101, 3'b101, 3'b111, 3'b100, 3'b110};
  logic [31:0] v_a  [13] = '{32'd7, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                             32'hFFFFFFF9, 32'd100, 32'd100, 32'hFFFFFFFF, 32'd5, 32'd5,
                             32'h80000000, 32'h80000000};
  logic [31:0] v_b  [13] = '{32'hFFFFFFFD, 32'd3, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2, 32'd7,
                             32'd7, 32'h80000001, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] v_exp[13] = '{32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF,
                             32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'd1, 32'hFFFFFFFF,
                             32'd5, 32'h80000000, 32'd0};
  int          v_lat[13] = '{37, 37, 37, 37, 37, 37, 37, 37, 37, 1, 1, 1, 1};

  task automatic test_directed();
    logic [31:0] res;
    int lat, own, viol;
    for (int i = 0; i < 13; i++) begin
      do_op(v_op[i], v_a[i], v_b[i], res, lat, own, viol);
      checks += 4;
      if (res !== v_exp[i]) begin
        errors++; $display("FAIL directed_result[%0d]: got %h expected %h", i, res, v_exp[i]);
      end
      if (lat != v_lat[i]) begin
        errors++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, v_lat[i]);
      end
      if (own != ((v_lat[i] == 37) ? 36 : 0)) begin
        errors++; $display("FAIL directed_alu_own[%0d]: got %0d cycles", i, own);
      end
      if (viol != 0) begin
        errors++; $display("FAIL directed_protocol[%0d]: got %0d violations expected 0", i, viol);
      end
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      4:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] a, b, res, exp;
    logic [2:0]  o;
    int lat, own, viol, elat;
    for (int i = 0; i < 48; i++) begin
      o    = 3'($urandom_range(0, 7));
      a    = pick_operand();
      b    = pick_operand();
      exp  = ref_model(o, a, b);
      elat = (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 37;
      do_op(o, a, b, res, lat, own, viol);
      checks += 3;
      if (res !== exp) begin
        errors++; $display("FAIL random_result op=%0d a=%h b=%h: got %h expected %h",
                           o, a, b, res, exp);
      end
      if (lat != elat) begin
        errors++; $display("FAIL random_latency op=%0d: got %0d expected %0d", o, lat, elat);
      end
      if (viol != 0 || own != ((elat == 37) ? 36 : 0)) begin
        errors++; $display("FAIL random_protocol op=%0d: got viol=%0d own=%0d", o, viol, own);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int lat, own, viol;
    int stray = 0;
    do_op(3'b000, 32'd5, 32'd5, res, lat, own, viol);
    checks++;
    if (res !== 32'd25) begin errors++; $display("FAIL pre_reset_mul: got %h expected 19", res); end
    @(negedge clk);
    start = 1'b1; op = 3'b000; rs1 = $urandom; rs2 = $urandom;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n < 10; n++) begin
      @(negedge clk);
      if (done) stray++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks += 2;
    if (busy !== 1'b0 || done !== 1'b0 || alu_own !== 1'b0) begin
      errors++; $display("FAIL midreset_ctrl: got busy=%b done=%b own=%b expected 0", busy, done,
                         alu_own);
    end
    if (result !== 32'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      errors++; $display("FAIL midreset_data: got result=%h a=%h b=%h expected 0", result, alu_a,
                         alu_b);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    checks++;
    if (stray != 0) begin errors++; $display("FAIL midreset_no_done: got %0d expected 0", stray); end
    do_op(3'b000, 32'd3, 32'd4, res, lat, own, viol);
    checks += 2;
    if (res !== 32'd12) begin errors++; $display("FAIL midreset_next_mul: got %h expected c", res); end
    if (lat != 37 || viol != 0) begin
      errors++; $display("FAIL midreset_next_lat: got %0d/%0d expected 37/0", lat, viol);
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] a, b, exp, res, res2;
    int lat = -1;
    int lat2, own, viol;
    a   = $urandom;
    b   = 32'($urandom_range(1, 1000));
    exp = ref_model(3'b101, a, b);
    res = '0;
    @(negedge clk);
    start = 1'b1; op = 3'b101; rs1 = a; rs2 = b;
    @(posedge clk);
    #1;
    op = 3'($urandom_range(0, 7)); rs1 = $urandom; rs2 = $urandom;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = n;
        res = result;
      end
      op = 3'($urandom_range(0, 7)); rs1 = $urandom; rs2 = 32'($urandom_range(0, 3));
      if (lat > 0) break;
    end
    @(negedge clk);
    start = 1'b0;
    checks += 3;
    if (res !== exp) begin errors++; $display("FAIL busy_start_result: got %h expected %h", res, exp); end
    if (lat != 37) begin errors++; $display("FAIL busy_start_latency: got %0d expected 37", lat); end
    if (busy !== 1'b0 || result !== res) begin
      errors++; $display("FAIL busy_start_done_cycle: got busy=%b result=%h expected 0/%h", busy,
                         result, res);
    end
    do_op(3'b011, a, b, res2, lat2, own, viol);
    checks++;
    if (res2 !== ref_model(3'b011, a, b) || lat2 != 37 || viol != 0) begin
      errors++; $display("FAIL busy_start_next: got %h lat %0d expected %h lat 37", res2, lat2,
                         ref_model(3'b011, a, b));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_start_while_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
